pipe_stage_reg: RTL

//  Generic, parametrised inter-stage register for the 5-stage MIPS pipeline (replaces the

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_entry_reg.sv | 32 +++
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, header type and Tnew aging helper for the pipeline stage registers.
package pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned A3_W    = 5;
    localparam int unsigned DATA_W  = 32;

    // Fixed-width part of every stage entry. The full stage_entry_t (with its
    // per-instance Tnew width and lane count) is built on top of this in the
    // stage register itself, because those widths are instance parameters.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [A3_W-1:0]    a3;
    } stage_hdr_t;

    // Saturating Tnew reduction applied when an entry enters a stage.
    function automatic int unsigned tnew_age(input int unsigned tnew, input int unsigned dec);
        return (tnew > dec) ? (tnew - dec) : 0;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Single pipeline entry register with a valid bit, load and clear enables.
module pipe_entry_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Reset and clear both empty the entry and zero its payload; load replaces it.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ld_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register: valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble, Tnew aging on entry and bubble masking of the outputs.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned NLANES   = 2,
    parameter int unsigned TNEW_W   = 2,
    parameter int unsigned TNEW_DEC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [A3_W-1:0]          in_a3,
    input  logic [TNEW_W-1:0]        in_tnew,
    input  logic [DATA_W*NLANES-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic [DATA_W*NLANES-1:0] out_data,
    output logic [A3_W-1:0]          out_a3,
    output logic [TNEW_W-1:0]        out_tnew
);

    typedef struct packed {
        stage_hdr_t                     hdr;
        logic [TNEW_W-1:0]              tnew;
        logic [NLANES-1:0][DATA_W-1:0]  data;
    } stage_entry_t;

    localparam int unsigned ENTRY_W = $bits(stage_entry_t);

    stage_entry_t       in_entry;
    stage_entry_t       main_q;
    stage_entry_t       skid_q;
    logic [ENTRY_W-1:0] main_raw;
    logic [ENTRY_W-1:0] skid_raw;
    logic               main_vld_q;
    logic               skid_vld_q;
    logic               in_ready_q;
    logic               in_ready_d;

    logic               in_fire;
    logic               out_fire;
    logic               main_take;

    logic               main_ld_d;
    logic               main_vld_d;
    stage_entry_t       main_data_d;
    logic               skid_ld_d;
    logic               skid_vld_d;
    logic               skid_vld_next;

    // Format the incoming entry: only Tnew changes, aged by this stage's decrement.
    always_comb begin
        in_entry           = '0;
        in_entry.hdr.instr = in_instr;
        in_entry.hdr.pc    = in_pc;
        in_entry.hdr.a3    = in_a3;
        in_entry.tnew      = TNEW_W'(tnew_age(int'(in_tnew), TNEW_DEC));
        in_entry.data      = in_data;
    end

    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = main_vld_q && out_ready;
    assign main_take = !main_vld_q || out_fire;

    // Next-state steering. in_ready is ~skid_valid, so an input never fires while
    // the skid is occupied; when main is refilled from the skid the skid simply empties.
    always_comb begin
        main_ld_d   = main_take;
        main_vld_d  = skid_vld_q || in_fire;
        main_data_d = skid_vld_q ? skid_q : in_entry;

        skid_ld_d   = main_take ? skid_vld_q : in_fire;
        skid_vld_d  = !main_take && in_fire;

        skid_vld_next = skid_ld_d ? skid_vld_d : skid_vld_q;
        in_ready_d    = !skid_vld_next;
    end

    pipe_entry_reg #(
        .W (ENTRY_W)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (flush),
        .ld_i    (main_ld_d),
        .valid_i (main_vld_d),
        .data_i  (main_data_d),
        .valid_o (main_vld_q),
        .data_o  (main_raw)
    );

    pipe_entry_reg #(
        .W (ENTRY_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (flush),
        .ld_i    (skid_ld_d),
        .valid_i (skid_vld_d),
        .data_i  (in_entry),
        .valid_o (skid_vld_q),
        .data_o  (skid_raw)
    );

    assign main_q = stage_entry_t'(main_raw);
    assign skid_q = stage_entry_t'(skid_raw);

    // Registered ready: tracks the skid occupancy of the next cycle; open after reset/flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;

    // Bubbles present an all-zero entry so hazard logic and forwarding ignore them.
    always_comb begin
        out_valid = main_vld_q;
        out_instr = '0;
        out_pc    = '0;
        out_a3    = '0;
        out_tnew  = '0;
        out_data  = '0;
        if (main_vld_q) begin
            out_instr = main_q.hdr.instr;
            out_pc    = main_q.hdr.pc;
            out_a3    = main_q.hdr.a3;
            out_tnew  = main_q.tnew;
            out_data  = main_q.data;
        end
    end

endmodule
